poseidon_req_arbiter: RTL and testbench

Shares one Poseidon hash core among NUM_REQ independent requesters.
- Arbitration is round-robin at message granularity. Each message is BEATS field elements of DATA_W bits. The grant is locked until the message's final beat is accepted.
- An in-order tag FIFO records which requester owns each outstanding message. Core results are routed back to that requester.
- The block sits between requester stream ports and the core's io_input/io_output streams, in front of the Poseidon top level.

---
 rtl/poseidon_req_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_poseidon_req_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poseidon_req_arbiter.sv
// -----------------------------------------------------------------------------
// poseidon_req_arbiter
//
// Shares one Poseidon hash core between NUM_REQ requesters. Input messages of
// BEATS field elements are granted round-robin, one whole message at a time.
// The grant stays locked until the final beat is accepted. An in-order tag
// FIFO remembers which requester owns each message that is still inside the
// core. Core results are steered back to that owner.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   req_valid/ready    per-requester input handshake
//   req_last           requester end-of-message marker (only checked)
//   req_payload        requester r at [r*DATA_W +: DATA_W]
//   rsp_valid/ready    per-requester result handshake (rsp_valid is one-hot)
//   rsp_payload        result data, shared by all requesters
//   core_in_*          stream towards the core io_input port
//   core_out_*         stream from the core io_output port
//   outstanding        tag FIFO occupancy (messages inside the core)
//   err_beat           sticky: req_last disagreed with the beat counter
//   err_orphan         sticky: core output arrived with no tag outstanding
// -----------------------------------------------------------------------------
module poseidon_req_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 255,
    parameter int unsigned BEATS     = 3,
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_W-1:0]     req_payload,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_W-1:0]             rsp_payload,
    output logic                          core_in_valid,
    input  logic                          core_in_ready,
    output logic                          core_in_last,
    output logic [DATA_W-1:0]             core_in_payload,
    input  logic                          core_out_valid,
    output logic                          core_out_ready,
    input  logic                          core_out_last,
    input  logic [DATA_W-1:0]             core_out_payload,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          err_beat,
    output logic                          err_orphan
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned PW = $clog2(TAG_DEPTH);
    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [GW:0]   REQ_CNT   = (GW + 1)'(NUM_REQ);
    localparam logic [GW-1:0] LAST_REQ  = GW'(NUM_REQ - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(TAG_DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Arbiter state
    state_e          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            err_beat_q, err_beat_d;
    logic            err_orphan_q, err_orphan_d;

    // Tag FIFO
    logic [GW-1:0]   tag_mem [TAG_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;

    logic [DATA_W-1:0]      req_data [NUM_REQ];
    logic [2*NUM_REQ-1:0]   valid_dbl;
    logic [NUM_REQ-1:0]     valid_rot;
    logic [GW-1:0]          pick_off;
    logic [GW:0]            pick_sum;
    logic [GW-1:0]          pick_idx;
    logic                   is_last_beat;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [GW-1:0]          head;
    logic                   push;
    logic                   pop;

    // Split the flat payload bus into one element per requester.
    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            req_data[r] = req_payload[r*DATA_W +: DATA_W];
        end
    end

    // Round-robin pick: rotate the valid vector so rr_ptr sits at bit 0, take
    // the lowest set bit, then add rr_ptr back modulo NUM_REQ.
    always_comb begin
        valid_dbl = {req_valid, req_valid} >> rr_ptr_q;
        valid_rot = valid_dbl[NUM_REQ-1:0];
        pick_off  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid_rot[i]) begin
                pick_off = GW'(i);
            end
        end
        pick_sum = {1'b0, rr_ptr_q} + {1'b0, pick_off};
        if (pick_sum >= REQ_CNT) begin
            pick_sum = pick_sum - REQ_CNT;
        end
        pick_idx = pick_sum[GW-1:0];
    end

    assign fifo_full    = (count_q == FULL_CNT);
    assign fifo_empty   = (count_q == '0);
    assign head         = tag_mem[rd_ptr_q];
    assign is_last_beat = (beat_cnt_q == LAST_BEAT);

    // Arbiter FSM: next state and request-side outputs.
    // NOTE: every output and next-state variable gets a default at the top of
    // the block so no path through the case statement can infer a latch.
    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_d         = grant_q;
        beat_cnt_d      = beat_cnt_q;
        err_beat_d      = err_beat_q;
        push            = 1'b0;
        req_ready       = '0;
        core_in_valid   = 1'b0;
        core_in_last    = 1'b0;
        core_in_payload = '0;

        case (state_q)
            IDLE: begin
                // One bubble cycle per message; a full FIFO only blocks new grants.
                if ((|req_valid) && !fifo_full) begin
                    grant_d = pick_idx;
                    push    = 1'b1;
                    state_d = STREAM;
                end
            end

            STREAM: begin
                core_in_valid       = req_valid[grant_q];
                core_in_payload     = req_data[grant_q];
                // The core's last marker comes from our own counter; req_last
                // is only compared against it.
                core_in_last        = is_last_beat;
                req_ready[grant_q]  = core_in_ready;

                if (req_valid[grant_q] && core_in_ready) begin
                    if (req_last[grant_q] != is_last_beat) begin
                        err_beat_d = 1'b1;
                    end
                    if (is_last_beat) begin
                        beat_cnt_d = '0;
                        rr_ptr_d   = (grant_q == LAST_REQ) ? '0 : grant_q + 1'b1;
                        state_d    = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Response routing, independent of the arbiter state. Results may span
    // several beats; the tag is released only on the core's last beat.
    always_comb begin
        rsp_valid      = '0;
        core_out_ready = 1'b0;
        rsp_payload    = core_out_payload;
        err_orphan_d   = err_orphan_q;
        pop            = 1'b0;

        if (!fifo_empty) begin
            rsp_valid[head] = core_out_valid;
            core_out_ready  = rsp_ready[head];
            pop             = core_out_valid && rsp_ready[head] && core_out_last;
        end else if (core_out_valid) begin
            err_orphan_d = 1'b1;
        end
    end

    // Tag FIFO pointers; they wrap naturally at TAG_DEPTH, the extra count bit
    // separates full from empty.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the values that were present before this clock edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            beat_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_beat_q   <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            beat_cnt_q   <= beat_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_beat_q   <= err_beat_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // NOTE: the tag storage itself is not reset; the pointers and count
    // decide which entries are valid, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= pick_idx;
        end
    end

    assign outstanding = count_q;
    assign err_beat    = err_beat_q;
    assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_poseidon_req_arbiter.sv
`timescale 1ns/1ps
module tb_poseidon_req_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 255;
    localparam int BEATS     = 3;
    localparam int TAG_DEPTH = 8;
    localparam int CW        = $clog2(TAG_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    typedef struct packed {
        logic [7:0]        req;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic                       clk = 1'b0;
    logic                       resetn = 1'b0;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         req_last = '0;
    logic [NUM_REQ*DATA_W-1:0]  req_payload = '0;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [NUM_REQ-1:0]         rsp_ready = '1;
    logic [DATA_W-1:0]          rsp_payload;
    logic                       core_in_valid;
    logic                       core_in_ready = 1'b1;
    logic                       core_in_last;
    logic [DATA_W-1:0]          core_in_payload;
    logic                       core_out_valid;
    logic                       core_out_ready;
    logic                       core_out_last;
    logic [DATA_W-1:0]          core_out_payload = '0;
    logic [CW-1:0]              outstanding;
    logic                       err_beat;
    logic                       err_orphan;

    // Bench-side core model controls
    logic              cout_v    = 1'b0;
    logic              orphan_en = 1'b0;
    logic              cin_stall = 1'b0;
    logic [DATA_W-1:0] acc       = '0;

    assign core_out_valid = cout_v | orphan_en;
    assign core_out_last  = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    beat_t             exp_in  [$];
    rsp_t              exp_rsp [$];
    logic [DATA_W-1:0] core_res[$];
    beat_t             rq [NUM_REQ][$];

    always #5 clk = ~clk;

    poseidon_req_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .BEATS     (BEATS),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_last         (req_last),
        .req_payload      (req_payload),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_payload      (rsp_payload),
        .core_in_valid    (core_in_valid),
        .core_in_ready    (core_in_ready),
        .core_in_last     (core_in_last),
        .core_in_payload  (core_in_payload),
        .core_out_valid   (core_out_valid),
        .core_out_ready   (core_out_ready),
        .core_out_last    (core_out_last),
        .core_out_payload (core_out_payload),
        .outstanding      (outstanding),
        .err_beat         (err_beat),
        .err_orphan       (err_orphan)
    );

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk_beat(input int r, input int m, input int k);
        logic [DATA_W-1:0] v;
        v = '0;
        v[39:0] = {16'hC0DE, 8'(r), 8'(m), 8'(k)};
        v[DATA_W-1 -: 8] = 8'(r * 16 + k) ^ 8'hA5;
        return v;
    endfunction

    // Queue one message on requester r and record what the core and the
    // requester should see, in the order the arbiter is expected to grant.
    task automatic send_msg(input int r, input int m, input logic [BEATS-1:0] last_pat);
        beat_t             b;
        rsp_t              e;
        logic [DATA_W-1:0] x;
        x = '0;
        for (int k = 0; k < BEATS; k++) begin
            b.data = mk_beat(r, m, k);
            b.last = last_pat[k];
            rq[r].push_back(b);
            b.last = (k == BEATS - 1);
            exp_in.push_back(b);
            x = x ^ b.data;
        end
        e.req  = 8'(r);
        e.data = x;
        exp_rsp.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic flush_tb();
        exp_in.delete();
        exp_rsp.delete();
        core_res.delete();
        acc = '0;
        for (int r = 0; r < NUM_REQ; r++) rq[r].delete();
    endtask

    task automatic apply_reset();
        step();
        resetn = 1'b0;
        step();
        flush_tb();
    endtask

    task automatic release_reset();
        step();
        resetn = 1'b1;
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_outstanding"},    outstanding,    '0);
        check({tag, "_req_ready"},      req_ready,      '0);
        check({tag, "_rsp_valid"},      rsp_valid,      '0);
        check({tag, "_core_in_valid"},  core_in_valid,  '0);
        check({tag, "_core_in_last"},   core_in_last,   '0);
        check({tag, "_core_out_ready"}, core_out_ready, '0);
        check({tag, "_err_beat"},       err_beat,       '0);
        check({tag, "_err_orphan"},     err_orphan,     '0);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i;
        i = 0;
        while ((exp_in.size() != 0 || exp_rsp.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({name, "_drained"}, DATA_W'(exp_in.size() + exp_rsp.size()), '0);
        @(negedge clk);
        @(negedge clk);
        check({name, "_outstanding_zero"}, outstanding, '0);
    endtask

    // Requester drivers: present the head of each requester queue, retire it
    // after an accepted handshake.
    initial begin : req_driver
        logic [NUM_REQ-1:0] hs_req;
        forever begin
            @(negedge clk);
            hs_req = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (hs_req[r] && rq[r].size() > 0) void'(rq[r].pop_front());
                if (rq[r].size() > 0) begin
                    req_valid[r] = 1'b1;
                    req_last[r]  = rq[r][0].last;
                    req_payload[r*DATA_W +: DATA_W] = rq[r][0].data;
                end else begin
                    req_valid[r] = 1'b0;
                    req_last[r]  = 1'b0;
                end
            end
        end
    end

    // Core model: result of a message is the XOR of its beats, one result
    // beat per message, returned in order.
    initial begin : core_model
        logic hs_out;
        forever begin
            @(negedge clk);
            hs_out = core_out_valid && core_out_ready;
            if (resetn && core_in_valid && core_in_ready) begin
                acc = acc ^ core_in_payload;
                if (core_in_last) begin
                    core_res.push_back(acc);
                    acc = '0;
                end
            end
            @(posedge clk);
            #1;
            if (hs_out && core_res.size() > 0) void'(core_res.pop_front());
            cout_v           = (core_res.size() > 0);
            core_out_payload = cout_v ? core_res[0] : '0;
            core_in_ready    = cin_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard monitor: compares every accepted core beat and every
    // delivered result against the expected queues.
    initial begin : monitor
        beat_t b;
        rsp_t  e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (core_in_valid && core_in_ready) begin
                    if (exp_in.size() == 0) begin
                        check("core_in_unexpected_beat", core_in_payload, '0);
                    end else begin
                        b = exp_in.pop_front();
                        check("core_in_payload", core_in_payload, b.data);
                        check("core_in_last", core_in_last, b.last);
                    end
                end
                if (rsp_valid != '0) begin
                    check("rsp_valid_onehot", $onehot(rsp_valid), 1);
                end
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (rsp_valid[r] && rsp_ready[r]) begin
                        if (exp_rsp.size() == 0) begin
                            check("rsp_unexpected", rsp_payload, '0);
                        end else begin
                            e = exp_rsp.pop_front();
                            check("rsp_owner", DATA_W'(r), DATA_W'(e.req));
                            check("rsp_payload", rsp_payload, e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
        $fatal(1, "watchdog timeout");
    end

    task automatic test_single();
        logic [DATA_W-1:0] x;
        x = mk_beat(1, 0, 0) ^ mk_beat(1, 0, 1) ^ mk_beat(1, 0, 2);
        step();
        rsp_ready = '0;
        @(negedge clk);
        check("t1_outstanding_before", outstanding, '0);
        step();
        send_msg(1, 0, 3'b100);
        for (int i = 0; i < 20 && !core_in_valid; i++) @(negedge clk);
        check("t1_stream_started", core_in_valid, 1);
        check("t1_outstanding_one", outstanding, 1);
        for (int i = 0; i < 40 && rsp_valid == '0; i++) @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 4'b0010);
        check("t1_rsp_payload", rsp_payload, x);
        check("t1_core_out_ready_held", core_out_ready, 0);
        step();
        rsp_ready = '1;
        wait_drain("t1", 50);
    endtask

    task automatic test_round_robin();
        apply_reset();
        cin_stall = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int r = 0; r < NUM_REQ; r++) send_msg(r, 10 + p * NUM_REQ + r, 3'b100);
        end
        release_reset();
        wait_drain("t2", 600);
        cin_stall = 1'b0;
    endtask

    task automatic test_full();
        int i;
        step();
        rsp_ready = '0;
        for (int m = 0; m < TAG_DEPTH + 1; m++) send_msg(3, 20 + m, 3'b100);
        i = 0;
        while (outstanding != CW'(TAG_DEPTH) && i < 100) begin
            @(negedge clk);
            i++;
        end
        check("t3_reached_full", outstanding, TAG_DEPTH);
        repeat (8) @(negedge clk);
        check("t3_full_outstanding", outstanding, TAG_DEPTH);
        check("t3_full_req_ready", req_ready, '0);
        check("t3_full_no_stream", core_in_valid, 0);
        step();
        rsp_ready = 4'b1000;
        step();
        rsp_ready = '0;
        @(negedge clk);
        check("t3_after_pop_outstanding", outstanding, TAG_DEPTH - 1);
        check("t3_after_pop_req_ready", req_ready, '0);
        @(negedge clk);
        check("t3_regrant_outstanding", outstanding, TAG_DEPTH);
        check("t3_regrant_req_ready", req_ready, 4'b1000);
        step();
        rsp_ready = '1;
        wait_drain("t3", 300);
    endtask

    task automatic test_bad_last();
        @(negedge clk);
        check("t4_err_beat_before", err_beat, 0);
        step();
        send_msg(2, 40, 3'b001);
        wait_drain("t4", 60);
        check("t4_err_beat_set", err_beat, 1);
        repeat (3) @(negedge clk);
        check("t4_err_beat_sticky", err_beat, 1);
    endtask

    task automatic test_orphan();
        check("t5_err_orphan_before", err_orphan, 0);
        step();
        orphan_en = 1'b1;
        @(negedge clk);
        check("t5_core_out_ready", core_out_ready, 0);
        check("t5_rsp_valid", rsp_valid, '0);
        step();
        orphan_en = 1'b0;
        @(negedge clk);
        check("t5_err_orphan_set", err_orphan, 1);
        @(negedge clk);
        check("t5_err_orphan_sticky", err_orphan, 1);
    endtask

    task automatic test_mid_reset();
        bit seen;
        seen = 1'b0;
        step();
        send_msg(0, 50, 3'b100);
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (core_in_valid && core_in_ready && core_in_payload == mk_beat(0, 50, 1)) seen = 1'b1;
        end
        check("t6_beat2_seen", seen, 1);
        resetn = 1'b0;
        @(posedge clk);
        #2;
        flush_tb();
        check_reset_state("t6");
        // rr_ptr was 3 before the reset; after it requester 0 must win over 3.
        send_msg(0, 60, 3'b100);
        send_msg(3, 61, 3'b100);
        release_reset();
        wait_drain("t6", 100);
    endtask

    initial begin : stimulus
        apply_reset();
        check_reset_state("rst");
        release_reset();
        test_single();
        test_round_robin();
        test_full();
        test_bad_last();
        test_orphan();
        test_mid_reset();
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
